// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the datapath it steers.
// The master side is the sequencer; the slave side is the datapath or bench.
interface alu_control_sequencer_if;
    logic        Start;
    logic [31:0] IR;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic        IncPC;
    logic        Read;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  opcode;
    logic        Busy;
    logic        Done;
    logic        Illegal;

    modport master (
        input  Start, IR,
        output PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
        output IncPC, Read, Rin, Rout, opcode, Busy, Done, Illegal
    );

    modport slave (
        output Start, IR,
        input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
        input  IncPC, Read, Rin, Rout, opcode, Busy, Done, Illegal
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute sequencer (T0..T5) for three-register ALU instructions.
// One instruction per accepted Start; strobes are decoded from the registered state.
module alu_control_sequencer #(
    parameter int         MEM_WAIT   = 2,
    parameter logic [4:0] ALU_OP_MAX = 5'd11
) (
    input  logic                   Clock,
    input  logic                   Clear,
    alu_control_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        DONE = 3'd7
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       illegal_q;

    logic [4:0] ir_op;
    logic [3:0] ir_ra, ir_rb, ir_rc;
    logic       op_illegal;
    logic       unused_ir_bits;

    assign ir_op          = bus.IR[31:27];
    assign ir_ra          = bus.IR[26:23];
    assign ir_rb          = bus.IR[22:19];
    assign ir_rc          = bus.IR[18:15];
    assign op_illegal     = (ir_op > ALU_OP_MAX);
    assign unused_ir_bits = ^bus.IR[14:0];

    function automatic logic [15:0] reg_select(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state     <= T0;
                        illegal_q <= 1'b0;
                    end
                end
                T0: begin
                    state    <= T1;
                    wait_cnt <= WAIT_INIT;
                end
                T1: begin
                    // Hold the read for MEM_WAIT extra cycles of memory latency.
                    if (wait_cnt == 4'd0) begin
                        state <= T2;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                T2: state <= T3;
                T3: begin
                    if (op_illegal) begin
                        illegal_q <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= T4;
                    end
                end
                T4:      state <= T5;
                T5:      state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // T3 strobes depend on the IR loaded by the edge that enters T3, so the
    // strobes cannot be registered a cycle early; they are decoded from state.
    always_comb begin
        bus.PCout  = 1'b0;
        bus.Zlowout = 1'b0;
        bus.MDRout = 1'b0;
        bus.MARin  = 1'b0;
        bus.Zin    = 1'b0;
        bus.MDRin  = 1'b0;
        bus.IRin   = 1'b0;
        bus.Yin    = 1'b0;
        bus.IncPC  = 1'b0;
        bus.Read   = 1'b0;
        bus.Rin    = 16'h0000;
        bus.Rout   = 16'h0000;
        bus.opcode = 5'd0;
        bus.Done   = 1'b0;
        case (state)
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            T1: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                if (!op_illegal) begin
                    bus.Rout = reg_select(ir_rb);
                    bus.Yin  = 1'b1;
                end
            end
            T4: begin
                bus.Rout   = reg_select(ir_rc);
                bus.Zin    = 1'b1;
                bus.opcode = ir_op;
            end
            T5: begin
                bus.Zlowout = 1'b1;
                bus.Rin     = reg_select(ir_ra);
            end
            DONE:    bus.Done = 1'b1;
            default: ;
        endcase
    end

    assign bus.Busy     = (state != IDLE);
    assign bus.Illegal  = illegal_q;
    assign bus.Zhighout = 1'b0;
    assign bus.HIout    = 1'b0;
    assign bus.LOout    = 1'b0;
    assign bus.HIin     = 1'b0;
    assign bus.LOin     = 1'b0;
    assign bus.PCin     = 1'b0;

endmodule
